// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the RV64 load/store unit:
//                FSM state enum, funct3 width codes and the access-error rule.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Load width/sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store width codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Misalignment for the access width, or a funct3 with no defined meaning.
    function automatic logic access_err(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [2:0] off);
        logic misaligned;
        case (funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off[1:0] != 2'b00);
            2'b11:   misaligned = (off != 3'b000);
            default: misaligned = 1'b0;
        endcase
        return misaligned | (!is_store && (funct3 == 3'b111)) | (is_store && funct3[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational byte-lane logic: load extraction with sign or
//                zero extension, and store merge into a doubleword.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] dword_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_data_o,
    output logic [63:0] merge_data_o
);

    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic [7:0]  w_base_en;
    logic [7:0]  w_byte_en;
    logic [63:0] w_bit_mask;

    assign w_shamt   = {off_i, 3'b000};
    assign w_shifted = dword_i >> w_shamt;

    // Select the addressed bytes and extend them to 64 bits.
    always_comb begin
        load_data_o = 64'd0;
        case (funct3_i)
            F3_LB:   load_data_o = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_LH:   load_data_o = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   load_data_o = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_LD:   load_data_o = w_shifted;
            F3_LBU:  load_data_o = {56'd0, w_shifted[7:0]};
            F3_LHU:  load_data_o = {48'd0, w_shifted[15:0]};
            F3_LWU:  load_data_o = {32'd0, w_shifted[31:0]};
            default: load_data_o = 64'd0;
        endcase
    end

    // Replace the addressed byte lanes of the doubleword with store data.
    always_comb begin
        w_base_en = 8'h00;
        case ({1'b0, funct3_i[1:0]})
            F3_SB:   w_base_en = 8'h01;
            F3_SH:   w_base_en = 8'h03;
            F3_SW:   w_base_en = 8'h0F;
            F3_SD:   w_base_en = 8'hFF;
            default: w_base_en = 8'h00;
        endcase
        w_byte_en = w_base_en << off_i;
        for (int b = 0; b < 8; b++) begin
            w_bit_mask[8*b +: 8] = {8{w_byte_en[b]}};
        end
        merge_data_o = (dword_i & ~w_bit_mask) | ((wdata_i << w_shamt) & w_bit_mask);
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding RV64 load/store unit. Loads read one
//                doubleword; sub-doubleword stores read-modify-write; SD can
//                bypass the read. Misaligned/illegal accesses answer at once.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit SD_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    lsu_state_e  state_q,    state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q,   funct3_d;
    logic [63:0] addr_q,     addr_d;
    logic [63:0] wdata_q,    wdata_d;
    logic [63:0] buf_q,      buf_d;
    logic [63:0] rdata_q,    rdata_d;
    logic        err_q,      err_d;

    logic        w_acc_err;
    logic [63:0] w_align_dword;
    logic [63:0] w_load_data;
    logic [63:0] w_merge_data;

    assign w_acc_err = access_err(req_is_store, req_funct3, req_addr[2:0]);

    // Loads extract straight from the memory word during RD; merges use the buffer.
    assign w_align_dword = (state_q == ST_RD) ? mem_rdata : buf_q;

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .off_i        (addr_q[2:0]),
        .dword_i      (w_align_dword),
        .wdata_i      (wdata_q),
        .load_data_o  (w_load_data),
        .merge_data_o (w_merge_data)
    );

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // State and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            buf_q      <= 64'd0;
            rdata_q    <= 64'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state and output decode; memory enables are driven only in RD/WR.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 64'd0;
        mem_wdata  = 64'd0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    err_d      = w_acc_err;
                    rdata_d    = 64'd0;
                    if (w_acc_err) begin
                        state_d = ST_RESP;
                    end else if (req_is_store && SD_BYPASS && (req_funct3 == F3_SD)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[63:3], 3'b000};
                buf_d    = mem_rdata;
                if (is_store_q) begin
                    state_d = ST_WR;
                end else begin
                    rdata_d = w_load_data;
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[63:3], 3'b000};
                mem_wdata = w_merge_data;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: SD_BYPASS, default 1, meaning: when 1, an SD store skips the read phase and writes directly.
REQ-002 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  1  core presents an access.
REQ-005 Port: req_ready  out  1  unit accepts an access; high only in IDLE.
REQ-006 Port: req_is_store  in  1  1=store, 0=load.
REQ-007 Port: req_funct3  in  3  RV64 width/sign code.
REQ-008 Port: req_addr  in  64  byte address.
REQ-009 Port: req_wdata  in  64  store data, right-aligned.
REQ-010 Port: resp_valid  out  1  response available.
REQ-011 Port: resp_ready  in  1  core consumes the response.
REQ-012 Port: resp_rdata  out  64  extended load data; 0 for stores and errors.
REQ-013 Port: resp_err  out  1  misaligned address or illegal funct3.
REQ-014 Port: mem_read, mem_write  out  1 each  data-memory enables.
REQ-015 Port: mem_addr  out  64  doubleword address, with bits [2:0] forced to 0.
REQ-016 Port: mem_wdata  out  64  merged doubleword.
REQ-017 Port: mem_rdata  in  64  combinational read data from memory (same-cycle).

Function
REQ-018 The FSM SHALL have four states: IDLE, RD, WR and RESP.
REQ-019 Transitions from IDLE:
- On req_valid&&req_ready with an error, go to RESP.
- For a load, go to RD.
- For a store, go to RD; go to WR instead when SD_BYPASS=1 and funct3=011.
REQ-020 The request SHALL be latched into internal registers on acceptance; request inputs are ignored outside IDLE.
REQ-021 RD SHALL:
- assert mem_read=1 for exactly one cycle;
- capture mem_rdata into a 64-bit buffer;
- go to RESP for a load, or to WR for a store.
REQ-022 WR SHALL:
- assert mem_write=1 for exactly one cycle;
- drive mem_wdata as the buffer with bytes [off+n-1:off] replaced by req_wdata[8n-1:0], where off=addr[2:0] and n=1/2/4/8;
- go to RESP.
REQ-023 RESP SHALL hold resp_valid=1 and resp_rdata/resp_err stable until resp_ready=1, then return to IDLE.
REQ-024 Load extraction SHALL select bytes from addr[2:0] (little-endian):
- LB/LH/LW (000/001/010) sign-extend to 64 bits;
- LBU/LHU/LWU (100/101/110) zero-extend;
- LD (011) passes the doubleword through.
REQ-025 Errors SHALL be flagged for:
- halfword with addr[0]≠0;
- word with addr[1:0]≠0;
- doubleword with addr[2:0]≠0;
- load funct3=111;
- store funct3≥100.
An error access SHALL produce no mem_read or mem_write.
REQ-026 Latency from the acceptance edge to resp_valid:
- load: 2 cycles;
- sub-doubleword store: 3 cycles;
- bypassed SD: 2 cycles;
- error: 1 cycle.
REQ-027 mem_read and mem_write SHALL never be high in the same cycle; mem_read, mem_write, mem_addr and mem_wdata SHALL be 0 in IDLE and RESP.
REQ-028 Throughput SHALL be one outstanding access; req_ready=0 from acceptance until the cycle after the resp_valid&&resp_ready handshake.

Reset
REQ-029 rst_n=0 SHALL immediately force:
- state=IDLE;
- resp_valid=0, resp_err=0, resp_rdata=0;
- mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0;
- the buffer and latched request cleared.
REQ-030 Reset asserted during WR SHALL deassert mem_write before the next clock edge, so no write occurs; a pending response is discarded.
REQ-031 req_ready SHALL be 1 on the first cycle after rst_n deasserts.

Structure
REQ-032 Package lsu_pkg SHALL hold the state enum and the funct3 constants LB..LWU and SB..SD.
REQ-033 The combinational extract/merge/sign-extend logic SHALL be a sub-module, lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-034 Initial memory dword 0x10 holds 0x8877665544332211. LB at 0x13 -> resp_rdata=0x0000000000000044, two cycles after acceptance.
REQ-035 Same memory. LH at 0x16 -> resp_rdata=0xFFFFFFFFFFFF8877; LHU at 0x16 -> 0x0000000000008877.
REQ-036 SB 0xAB to 0x11 -> one mem_read, then one mem_write with mem_wdata=0x887766554433AB11; a subsequent LD at 0x10 returns that value.
REQ-037 SD 0x0123456789ABCDEF to 0x18 with SD_BYPASS=1 -> no mem_read, a single mem_write, resp_valid two cycles after acceptance.
REQ-038 LW at 0x22 -> resp_err=1, resp_rdata=0, no memory enables, resp_valid one cycle after acceptance; resp_ready held 0 for 3 cycles -> response stays stable.
REQ-039 rst_n pulsed low during the WR of SW 0xDEADBEEF to 0x20 -> dword 0x20 unchanged, req_ready=1 after release.
